// File: rtl/ex_stage_if.sv
// Decode-to-execute handshake and the registered E->M latch outputs of ex_stage.
// The master side is the decode/hazard logic; the slave side is ex_stage.
interface ex_stage_if #(
    parameter int WORD_W = 32
);
    logic              stall_i;
    logic              bubble_i;
    logic              in_valid_i;
    logic [7:0]        icode_i;
    logic [7:0]        ifun_i;
    logic [WORD_W-1:0] valA_i;
    logic [WORD_W-1:0] valB_i;
    logic [WORD_W-1:0] valC_i;
    logic [7:0]        dstE_i;
    logic [7:0]        dstM_i;

    logic              valid_o;
    logic [7:0]        icode_o;
    logic              cnd_o;
    logic [WORD_W-1:0] valE_o;
    logic [WORD_W-1:0] valA_o;
    logic [7:0]        dstE_o;
    logic [7:0]        dstM_o;
    logic [2:0]        cc_o;
    logic              halt_o;

    modport master (
        output stall_i, bubble_i, in_valid_i, icode_i, ifun_i,
               valA_i, valB_i, valC_i, dstE_i, dstM_i,
        input  valid_o, icode_o, cnd_o, valE_o, valA_o, dstE_o, dstM_o,
               cc_o, halt_o
    );

    modport slave (
        input  stall_i, bubble_i, in_valid_i, icode_i, ifun_i,
               valA_i, valB_i, valC_i, dstE_i, dstM_i,
        output valid_o, icode_o, cnd_o, valE_o, valA_o, dstE_o, dstM_o,
               cc_o, halt_o
    );
endinterface

// File: rtl/ex_stage.sv
// Y86 execute stage: ALU, condition-code register, jXX/cmovXX evaluation,
// and the E->M pipeline latch with stall, bubble and sticky halt.
module ex_stage #(
    parameter int WORD_W     = 32,
    parameter int STACK_STEP = WORD_W / 8
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave ex
);
    localparam int MSB = WORD_W - 1;
    localparam logic [WORD_W-1:0] STEP = WORD_W'(STACK_STEP);

    localparam logic [7:0] I_HALT   = 8'h00;
    localparam logic [7:0] I_NOP    = 8'h01;
    localparam logic [7:0] I_RRMOVL = 8'h02;
    localparam logic [7:0] I_IRMOVL = 8'h03;
    localparam logic [7:0] I_RMMOVL = 8'h04;
    localparam logic [7:0] I_MRMOVL = 8'h05;
    localparam logic [7:0] I_OPL    = 8'h06;
    localparam logic [7:0] I_CALL   = 8'h08;
    localparam logic [7:0] I_RET    = 8'h09;
    localparam logic [7:0] I_PUSHL  = 8'h0A;
    localparam logic [7:0] I_POPL   = 8'h0B;
    localparam logic [7:0] RNONE    = 8'h0F;

    typedef struct packed {
        logic              valid;
        logic [7:0]        icode;
        logic              cnd;
        logic [WORD_W-1:0] val_e;
        logic [WORD_W-1:0] val_a;
        logic [7:0]        dst_e;
        logic [7:0]        dst_m;
    } em_t;

    em_t               em_q, em_d, em_bubble, em_new;
    logic [2:0]        cc_q, cc_d;
    logic              halt_q, halt_d;
    logic [WORD_W-1:0] a, b, c, alu_e;
    logic              zf, sf, of, cnd, new_of, cc_upd, accept;

    assign a  = ex.valA_i;
    assign b  = ex.valB_i;
    assign c  = ex.valC_i;
    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    // Conditions read the flags from before this instruction.
    always_comb begin
        cnd = 1'b0;
        case (ex.ifun_i)
            8'd0:    cnd = 1'b1;
            8'd1:    cnd = (sf ^ of) | zf;
            8'd2:    cnd = sf ^ of;
            8'd3:    cnd = zf;
            8'd4:    cnd = ~zf;
            8'd5:    cnd = ~(sf ^ of);
            8'd6:    cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end

    always_comb begin
        alu_e  = '0;
        new_of = 1'b0;
        cc_upd = 1'b0;
        case (ex.icode_i)
            I_RRMOVL:         alu_e = a;
            I_IRMOVL:         alu_e = c;
            I_RMMOVL,
            I_MRMOVL:         alu_e = b + c;
            I_CALL, I_PUSHL:  alu_e = b - STEP;
            I_RET, I_POPL:    alu_e = b + STEP;
            I_OPL: begin
                case (ex.ifun_i)
                    8'd0: begin
                        alu_e  = b + a;
                        new_of = (a[MSB] == b[MSB]) && (alu_e[MSB] != b[MSB]);
                        cc_upd = 1'b1;
                    end
                    8'd1: begin
                        alu_e  = b - a;
                        new_of = (a[MSB] != b[MSB]) && (alu_e[MSB] != b[MSB]);
                        cc_upd = 1'b1;
                    end
                    8'd2: begin
                        alu_e  = b & a;
                        cc_upd = 1'b1;
                    end
                    8'd3: begin
                        alu_e  = b ^ a;
                        cc_upd = 1'b1;
                    end
                    default: alu_e = '0;
                endcase
            end
            default: alu_e = '0;
        endcase
    end

    always_comb begin
        em_bubble       = '0;
        em_bubble.icode = I_NOP;
        em_bubble.dst_e = RNONE;
        em_bubble.dst_m = RNONE;

        em_new.valid = 1'b1;
        em_new.icode = ex.icode_i;
        em_new.cnd   = cnd;
        em_new.val_e = alu_e;
        em_new.val_a = a;
        // A failed cmov must not write its destination.
        em_new.dst_e = (ex.icode_i == I_RRMOVL && !cnd) ? RNONE : ex.dstE_i;
        em_new.dst_m = ex.dstM_i;

        accept = !ex.stall_i && !ex.bubble_i && ex.in_valid_i && !halt_q;

        em_d   = em_q;
        cc_d   = cc_q;
        halt_d = halt_q;
        if (!ex.stall_i) begin
            em_d = accept ? em_new : em_bubble;
        end
        if (accept && cc_upd) begin
            cc_d = {(alu_e == '0), alu_e[MSB], new_of};
        end
        if (accept && ex.icode_i == I_HALT) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            em_q   <= em_bubble;
            cc_q   <= 3'b100;
            halt_q <= 1'b0;
        end else begin
            em_q   <= em_d;
            cc_q   <= cc_d;
            halt_q <= halt_d;
        end
    end

    assign ex.valid_o = em_q.valid;
    assign ex.icode_o = em_q.icode;
    assign ex.cnd_o   = em_q.cnd;
    assign ex.valE_o  = em_q.val_e;
    assign ex.valA_o  = em_q.val_a;
    assign ex.dstE_o  = em_q.dst_e;
    assign ex.dstM_o  = em_q.dst_m;
    assign ex.cc_o    = cc_q;
    assign ex.halt_o  = halt_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic checked against
// an instruction-level Y86 execute model.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if #(.WORD_W(32)) bus ();
    ex_stage_if #(.WORD_W(64)) bus64 ();

    ex_stage #(.WORD_W(32)) u_dut   (.clk(clk), .rst(rst), .ex(bus));
    ex_stage #(.WORD_W(64)) u_dut64 (.clk(clk), .rst(rst), .ex(bus64));

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the architectural state and E->M latch (32-bit instance)
    logic        m_valid, m_cnd, m_halt;
    logic [7:0]  m_icode, m_dstE, m_dstM;
    logic [31:0] m_valE, m_valA;
    logic [2:0]  m_cc;

    localparam logic [93:0] RESET_VEC = {1'b0, 8'h01, 1'b0, 32'h0, 32'h0, 8'h0F, 8'h0F, 3'b100, 1'b0};

    function automatic logic [93:0] obs_vec();
        return {bus.valid_o, bus.icode_o, bus.cnd_o, bus.valE_o, bus.valA_o,
                bus.dstE_o, bus.dstM_o, bus.cc_o, bus.halt_o};
    endfunction

    function automatic logic [93:0] exp_vec();
        return {m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM, m_cc, m_halt};
    endfunction

    task automatic model_bubble();
        m_valid = 1'b0; m_icode = 8'h01; m_cnd = 1'b0;
        m_valE = '0; m_valA = '0; m_dstE = 8'h0F; m_dstM = 8'h0F;
    endtask

    // Applies the effect of the coming clock edge to the model.
    task automatic model_edge();
        logic zf, sf, of, c, upd, nof;
        logic [31:0] a, b, k, e;
        longint sa, sb, r;
        zf = m_cc[2]; sf = m_cc[1]; of = m_cc[0];
        if (!rst) begin
            model_bubble();
            m_cc = 3'b100; m_halt = 1'b0;
        end else if (bus.stall_i) begin
            // hold
        end else if (bus.bubble_i || !bus.in_valid_i || m_halt) begin
            model_bubble();
        end else begin
            a = bus.valA_i; b = bus.valB_i; k = bus.valC_i;
            sa = longint'($signed(a)); sb = longint'($signed(b));
            case (bus.ifun_i)
                8'd0: c = 1;
                8'd1: c = (sf != of) || zf;
                8'd2: c = (sf != of);
                8'd3: c = zf;
                8'd4: c = !zf;
                8'd5: c = (sf == of);
                8'd6: c = (sf == of) && !zf;
                default: c = 0;
            endcase
            e = 0; upd = 0; nof = 0;
            case (bus.icode_i)
                8'h02: e = a;
                8'h03: e = k;
                8'h04, 8'h05: e = b + k;
                8'h08, 8'h0A: e = b - 32'd4;
                8'h09, 8'h0B: e = b + 32'd4;
                8'h06: begin
                    if (bus.ifun_i == 0) begin
                        r = sb + sa; e = r[31:0]; upd = 1;
                        nof = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                    end else if (bus.ifun_i == 1) begin
                        r = sb - sa; e = r[31:0]; upd = 1;
                        nof = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                    end else if (bus.ifun_i == 2) begin
                        e = b & a; upd = 1;
                    end else if (bus.ifun_i == 3) begin
                        e = b ^ a; upd = 1;
                    end
                end
                default: e = 0;
            endcase
            m_valid = 1; m_icode = bus.icode_i; m_cnd = c; m_valE = e; m_valA = a;
            m_dstE = (bus.icode_i == 8'h02 && !c) ? 8'h0F : bus.dstE_i;
            m_dstM = bus.dstM_i;
            if (upd) m_cc = {e == 0, e[31], nof};
            if (bus.icode_i == 8'h00) m_halt = 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] ic, input logic [7:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] k,
                         input logic [7:0] de, input logic [7:0] dm);
        bus.in_valid_i = v; bus.icode_i = ic; bus.ifun_i = fn;
        bus.valA_i = a; bus.valB_i = b; bus.valC_i = k; bus.dstE_i = de; bus.dstM_i = dm;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 0; tick(); tick(); rst = 1;
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset: got %h want %h", obs_vec(), RESET_VEC);
        end
    endtask

    task automatic test_alu_directed();
        drive(1, 8'h06, 8'h00, 32'h7FFFFFFF, 32'h1, 0, 8'h2, 8'h0F); tick();
        n_tests++;
        if ({bus.valid_o, bus.valE_o, bus.cc_o} !== {1'b1, 32'h80000000, 3'b011}) begin
            n_fail++; $display("FAIL addl_ovf: got v=%b e=%h cc=%b want v=1 e=80000000 cc=011",
                               bus.valid_o, bus.valE_o, bus.cc_o);
        end
        drive(1, 8'h06, 8'h01, 32'd5, 32'd5, 0, 8'h2, 8'h0F); tick();
        drive(1, 8'h07, 8'h03, 0, 0, 32'h40, 8'h0F, 8'h0F); tick();
        n_tests++;
        if ({bus.cnd_o, bus.icode_o} !== {1'b1, 8'h07}) begin
            n_fail++; $display("FAIL je_after_sub: got cnd=%b ic=%h want cnd=1 ic=07", bus.cnd_o, bus.icode_o);
        end
        drive(1, 8'h06, 8'h03, 32'd1, 32'd0, 0, 8'h2, 8'h0F); tick();
        drive(1, 8'h02, 8'h03, 32'h55, 0, 0, 8'h3, 8'h0F); tick();
        n_tests++;
        if ({bus.cnd_o, bus.dstE_o, bus.valE_o} !== {1'b0, 8'h0F, 32'h55}) begin
            n_fail++; $display("FAIL cmove_fail: got cnd=%b dstE=%h e=%h want cnd=0 dstE=0f e=55",
                               bus.cnd_o, bus.dstE_o, bus.valE_o);
        end
        drive(1, 8'h0A, 8'h00, 32'h9, 32'h100, 0, 8'h4, 8'h0F); tick();
        n_tests++;
        if (bus.valE_o !== 32'hFC) begin
            n_fail++; $display("FAIL pushl: got %h want 000000fc", bus.valE_o);
        end
        drive(1, 8'h0B, 8'h00, 32'h9, 32'hFC, 0, 8'h4, 8'h0); tick();
        n_tests++;
        if (bus.valE_o !== 32'h100) begin
            n_fail++; $display("FAIL popl: got %h want 00000100", bus.valE_o);
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL directed_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        drive(1, 8'h06, 8'h00, 32'd3, 32'd4, 0, 8'h1, 8'h0F);
        bus.stall_i = 1;
        bus.bubble_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        bus.stall_i = 0; bus.bubble_i = 0;
        tick();
        n_tests++;
        if ({bus.valid_o, bus.valE_o, bus.cc_o} !== {1'b1, 32'd7, 3'b000}) begin
            n_fail++; $display("FAIL stall_release: got v=%b e=%h cc=%b want v=1 e=7 cc=000",
                               bus.valid_o, bus.valE_o, bus.cc_o);
        end
        bus.in_valid_i = 0; tick();
        n_tests++;
        if ({bus.valid_o, bus.cc_o} !== {1'b0, 3'b000}) begin
            n_fail++; $display("FAIL stall_once: got v=%b cc=%b want v=0 cc=000", bus.valid_o, bus.cc_o);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            bus.stall_i  = ($urandom_range(0, 99) < 15);
            bus.bubble_i = ($urandom_range(0, 99) < 10);
            drive($urandom_range(0, 99) < 85,
                  ($urandom_range(0, 9) == 0) ? 8'($urandom_range(12, 255)) : 8'($urandom_range(1, 11)),
                  ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
                  rand_word(), rand_word(), rand_word(),
                  8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            tick();
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                if (bad < 10) $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
                bad++;
            end
        end
        bus.stall_i = 0; bus.bubble_i = 0;
    endtask

    task automatic test_word64();
        bus64.icode_i = 8'h0A; bus64.valB_i = 64'h100; bus64.in_valid_i = 1;
        tick();
        n_tests++;
        if (bus64.valE_o !== 64'hF8) begin
            n_fail++; $display("FAIL push64: got %h want f8", bus64.valE_o);
        end
        bus64.icode_i = 8'h0B; bus64.valB_i = 64'hF8;
        tick();
        n_tests++;
        if (bus64.valE_o !== 64'h100) begin
            n_fail++; $display("FAIL pop64: got %h want 100", bus64.valE_o);
        end
        bus64.in_valid_i = 0;
    endtask

    task automatic test_reset_midstream();
        drive(1, 8'h06, 8'h01, 32'd9, 32'd2, 0, 8'h1, 8'h0F);
        bus.stall_i = 1; rst = 0;
        tick();
        rst = 1; bus.stall_i = 0;
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_over_stall: got %h want %h", obs_vec(), RESET_VEC);
        end
    endtask

    task automatic test_halt();
        drive(1, 8'h06, 8'h01, 32'd5, 32'd3, 0, 8'h1, 8'h0F); tick();
        drive(1, 8'h00, 8'h00, 0, 0, 0, 8'h0F, 8'h0F); tick();
        n_tests++;
        if ({bus.halt_o, bus.valid_o, bus.icode_o, bus.cc_o} !== {1'b1, 1'b1, 8'h00, 3'b010}) begin
            n_fail++; $display("FAIL halt_accept: got h=%b v=%b ic=%h cc=%b want h=1 v=1 ic=00 cc=010",
                               bus.halt_o, bus.valid_o, bus.icode_o, bus.cc_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h06, 8'h00, 32'h7FFFFFFF, 32'h1, 0, 8'h2, 8'h0F); tick();
            n_tests++;
            if ({bus.halt_o, bus.valid_o, bus.icode_o, bus.cc_o} !== {1'b1, 1'b0, 8'h01, 3'b010}) begin
                n_fail++; $display("FAIL halt_sticky[%0d]: got h=%b v=%b ic=%h cc=%b want h=1 v=0 ic=01 cc=010",
                                   i, bus.halt_o, bus.valid_o, bus.icode_o, bus.cc_o);
            end
        end
        rst = 0; tick(); rst = 1;
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL halt_reset: got %h want %h", obs_vec(), RESET_VEC);
        end
    endtask

    initial begin
        bus.stall_i = 0; bus.bubble_i = 0;
        drive(0, 8'h01, 8'h00, 0, 0, 0, 8'h0F, 8'h0F);
        bus64.stall_i = 0; bus64.bubble_i = 0; bus64.in_valid_i = 0;
        bus64.icode_i = 8'h01; bus64.ifun_i = 0;
        bus64.valA_i = 0; bus64.valB_i = 0; bus64.valC_i = 0;
        bus64.dstE_i = 8'h0F; bus64.dstM_i = 8'h0F;
        m_cc = 3'b100; m_halt = 0; model_bubble();

        test_reset();
        test_alu_directed();
        test_stall();
        test_random();
        test_word64();
        test_reset_midstream();
        test_halt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
